// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-host memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT_I = 3'd1,
      GRANT_D = 3'd2,
      WAIT_I  = 3'd3,
      WAIT_D  = 3'd4
   } arb_state_t;

   typedef enum logic {
      HOST_I = 1'b0,
      HOST_D = 1'b1
   } arb_host_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction host, data host and shared agent Avalon-MM buses.
// Latency: n/a (wiring only).
// Backpressure: waitrequest per port, readdatavalid qualifies readdata.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W_DEF,
   parameter int DATA_W = mem_port_arbiter_pkg::DATA_W_DEF
);
   logic                  i_read;
   logic [ADDR_W-1:0]     i_address;
   logic [DATA_W/8-1:0]   i_byteenable;
   logic                  i_waitrequest;
   logic [DATA_W-1:0]     i_readdata;
   logic                  i_readdatavalid;

   logic                  d_read;
   logic                  d_write;
   logic [ADDR_W-1:0]     d_address;
   logic [DATA_W/8-1:0]   d_byteenable;
   logic [DATA_W-1:0]     d_writedata;
   logic                  d_waitrequest;
   logic [DATA_W-1:0]     d_readdata;
   logic                  d_readdatavalid;

   logic                  m_read;
   logic                  m_write;
   logic [ADDR_W-1:0]     m_address;
   logic [DATA_W/8-1:0]   m_byteenable;
   logic [DATA_W-1:0]     m_writedata;
   logic                  m_waitrequest;
   logic [DATA_W-1:0]     m_readdata;
   logic                  m_readdatavalid;

   // Arbiter side: accepts host commands, drives the agent port.
   modport slave (
      input  i_read, i_address, i_byteenable,
      output i_waitrequest, i_readdata, i_readdatavalid,
      input  d_read, d_write, d_address, d_byteenable, d_writedata,
      output d_waitrequest, d_readdata, d_readdatavalid,
      output m_read, m_write, m_address, m_byteenable, m_writedata,
      input  m_waitrequest, m_readdata, m_readdatavalid
   );

   // Environment side: hosts and agent.
   modport master (
      output i_read, i_address, i_byteenable,
      input  i_waitrequest, i_readdata, i_readdatavalid,
      output d_read, d_write, d_address, d_byteenable, d_writedata,
      input  d_waitrequest, d_readdata, d_readdatavalid,
      input  m_read, m_write, m_address, m_byteenable, m_writedata,
      output m_waitrequest, m_readdata, m_readdatavalid
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-requester round-robin selector: on contention the host not granted last wins.
// Latency: purely combinational.
// Backpressure: none; winner is meaningless when neither host requests.
module rr_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic      req_i,
   input  logic      req_d,
   input  arb_host_t last,
   output arb_host_t winner
);

   // Solo requester wins outright; contention flips away from the last grant.
   always_comb begin
      winner = HOST_I;
      if (req_i && req_d)
         winner = (last == HOST_I) ? HOST_D : HOST_I;
      else if (req_d)
         winner = HOST_D;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM agent port between instruction (read-only) and data hosts, round-robin.
// Latency: 1 cycle arbitration, grant held until write accepted or read data returned.
// Backpressure: owner sees agent waitrequest; non-owner held with waitrequest=1.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   arb_state_t state, state_nxt;
   arb_host_t  last_grant, last_nxt, winner;
   logic       req_i, req_d;

   assign req_i = bus.i_read;
   assign req_d = bus.d_read | bus.d_write;

   // Read data is broadcast; readdatavalid alone identifies the owner.
   assign bus.i_readdata = bus.m_readdata;
   assign bus.d_readdata = bus.m_readdata;

   rr_pick2 u_pick (
      .req_i  (req_i),
      .req_d  (req_d),
      .last   (last_grant),
      .winner (winner)
   );

   // State and round-robin memory; async reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= HOST_I;
      end else begin
         state      <= state_nxt;
         last_grant <= last_nxt;
      end
   end

   // Next-state and command mux; agent bus is zero whenever no host owns it.
   always_comb begin
      state_nxt           = state;
      last_nxt            = last_grant;
      bus.m_read          = 1'b0;
      bus.m_write         = 1'b0;
      bus.m_address       = '0;
      bus.m_byteenable    = '0;
      bus.m_writedata     = '0;
      bus.i_waitrequest   = 1'b1;
      bus.d_waitrequest   = 1'b1;
      bus.i_readdatavalid = 1'b0;
      bus.d_readdatavalid = 1'b0;
      case (state)
         IDLE: begin
            if (req_i || req_d) begin
               state_nxt = (winner == HOST_D) ? GRANT_D : GRANT_I;
               last_nxt  = winner;
            end
         end
         GRANT_I: begin
            bus.m_read        = bus.i_read;
            bus.m_address     = bus.i_address;
            bus.m_byteenable  = bus.i_byteenable;
            bus.i_waitrequest = bus.m_waitrequest;
            if (!req_i)
               state_nxt = IDLE;
            else if (!bus.m_waitrequest)
               state_nxt = WAIT_I;
         end
         GRANT_D: begin
            // A simultaneous read+write is issued as the write.
            bus.m_write       = bus.d_write;
            bus.m_read        = bus.d_read & ~bus.d_write;
            bus.m_address     = bus.d_address;
            bus.m_byteenable  = bus.d_byteenable;
            bus.m_writedata   = bus.d_writedata;
            bus.d_waitrequest = bus.m_waitrequest;
            if (!req_d)
               state_nxt = IDLE;
            else if (!bus.m_waitrequest)
               state_nxt = bus.d_write ? IDLE : WAIT_D;
         end
         WAIT_I: begin
            if (bus.m_readdatavalid) begin
               bus.i_readdatavalid = 1'b1;
               state_nxt           = IDLE;
            end
         end
         WAIT_D: begin
            if (bus.m_readdatavalid) begin
               bus.d_readdatavalid = 1'b1;
               state_nxt           = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Host protocol checks: a granted host must hold its request; read+write is ambiguous.
   always @(posedge clk) begin
      if (rst) begin
         if (state == GRANT_I)
            assert (bus.i_read)
               else $warning("mem_port_arbiter: instruction host dropped read while granted");
         if (state == GRANT_D)
            assert (bus.d_read || bus.d_write)
               else $warning("mem_port_arbiter: data host dropped request while granted");
         assert (!(bus.d_read && bus.d_write))
            else $warning("mem_port_arbiter: d_read and d_write both high, issuing write");
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed cycle table, reset/read+write corner sequences, random traffic.
// Latency: n/a.
// Backpressure: bench plays both hosts and a random-wait, random-latency agent.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        ir, dr, dw;
      logic [31:0] ia, da, dwd;
      logic        mw, mrdv;
      logic [31:0] mrd;
      logic        e_mr, e_mw;
      logic [31:0] e_ma, e_mwd;
      logic        e_iw, e_dw, e_irdv, e_drdv;
      logic        chk_bus;
   } vec_t;

   vec_t vt [26];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic clr_in();
      bus.i_read = 0; bus.i_address = '0; bus.i_byteenable = '0;
      bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_byteenable = '0;
      bus.d_writedata = '0;
      bus.m_waitrequest = 0; bus.m_readdata = '0; bus.m_readdatavalid = 0;
   endtask

   task automatic do_reset();
      rst = 0;
      clr_in();
      repeat (2) @(posedge clk);
      #1 rst = 1;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, ".m_read"}, bus.m_read, 0);
      chk({nm, ".m_write"}, bus.m_write, 0);
      chk({nm, ".m_address"}, bus.m_address, 0);
      chk({nm, ".i_wait"}, bus.i_waitrequest, 1);
      chk({nm, ".d_wait"}, bus.d_waitrequest, 1);
   endtask

   // random-phase stimulus and reference state
   logic        ir_n, dr_n, dw_n, mw_n, mrdv_n;
   logic [31:0] ia_n, da_n, dwd_n, mrd_n;
   logic [3:0]  ibe_n, dbe_n;
   int          hi_st, hd_st, rd_cnt, lat;
   logic        hd_wr;
   bit          mdl_busy, mdl_wait;
   int          mdl_own, mdl_last;

   initial begin
      // rows: ir dr dw ia da dwd mw mrdv mrd | e_mr e_mw e_ma e_mwd e_iw e_dw e_irdv e_drdv chk_bus
      vt[0]  = '{0,0,1,0,'h100,'hDEADBEEF,0,0,0,        0,0,0,0,1,1,0,0,1};
      vt[1]  = '{0,0,1,0,'h100,'hDEADBEEF,0,0,0,        0,1,'h100,'hDEADBEEF,1,0,0,0,1};
      vt[2]  = '{0,0,0,0,0,0,0,0,0,                     0,0,0,0,1,1,0,0,1};
      vt[3]  = '{1,0,0,0,0,0,0,0,0,                     0,0,0,0,1,1,0,0,1};
      vt[4]  = '{1,0,0,0,0,0,0,0,0,                     1,0,0,0,0,1,0,0,1};
      vt[5]  = '{0,0,0,0,0,0,0,0,0,                     0,0,0,0,1,1,0,0,0};
      vt[6]  = '{0,0,0,0,0,0,0,1,'h13,                  0,0,0,0,1,1,1,0,0};
      vt[7]  = '{0,0,0,0,0,0,0,0,0,                     0,0,0,0,1,1,0,0,1};
      vt[8]  = '{1,1,0,'h40,'h200,0,0,0,0,              0,0,0,0,1,1,0,0,1};
      vt[9]  = '{1,1,0,'h40,'h200,0,0,0,0,              1,0,'h200,0,1,0,0,0,1};
      vt[10] = '{1,1,0,'h40,'h200,0,0,1,'hAAAA,         0,0,0,0,1,1,0,1,0};
      vt[11] = '{1,1,0,'h40,'h200,0,0,0,0,              0,0,0,0,1,1,0,0,1};
      vt[12] = '{1,1,0,'h40,'h200,0,0,0,0,              1,0,'h40,0,0,1,0,0,1};
      vt[13] = '{1,1,0,'h40,'h200,0,0,1,'hBBBB,         0,0,0,0,1,1,1,0,0};
      vt[14] = '{1,1,0,'h40,'h200,0,0,0,0,              0,0,0,0,1,1,0,0,1};
      vt[15] = '{1,1,0,'h40,'h200,0,0,0,0,              1,0,'h200,0,1,0,0,0,1};
      vt[16] = '{1,1,0,'h40,'h200,0,0,1,'hCCCC,         0,0,0,0,1,1,0,1,0};
      vt[17] = '{0,0,1,0,'h300,'h12345678,1,0,0,        0,0,0,0,1,1,0,0,1};
      vt[18] = '{1,0,1,'h40,'h300,'h12345678,1,0,0,     0,1,'h300,'h12345678,1,1,0,0,1};
      vt[19] = '{1,0,1,'h40,'h300,'h12345678,1,0,0,     0,1,'h300,'h12345678,1,1,0,0,1};
      vt[20] = '{1,0,1,'h40,'h300,'h12345678,1,0,0,     0,1,'h300,'h12345678,1,1,0,0,1};
      vt[21] = '{1,0,1,'h40,'h300,'h12345678,0,0,0,     0,1,'h300,'h12345678,1,0,0,0,1};
      vt[22] = '{1,0,0,'h40,0,0,0,0,0,                  0,0,0,0,1,1,0,0,1};
      vt[23] = '{1,0,0,'h40,0,0,0,0,0,                  1,0,'h40,0,0,1,0,0,1};
      vt[24] = '{0,0,0,0,0,0,0,1,'h55,                  0,0,0,0,1,1,1,0,0};
      vt[25] = '{0,0,0,0,0,0,0,0,0,                     0,0,0,0,1,1,0,0,1};

      // reset values, with requests present to show nothing leaks through
      rst = 0;
      clr_in();
      bus.i_read = 1; bus.d_write = 1; bus.d_address = 'h10; bus.d_writedata = 'h99;
      bus.m_readdatavalid = 1;
      #12;
      chk_idle("reset");
      chk("reset.m_be", bus.m_byteenable, 0);
      chk("reset.m_wd", bus.m_writedata, 0);
      chk("reset.i_rdv", bus.i_readdatavalid, 0);
      chk("reset.d_rdv", bus.d_readdatavalid, 0);
      do_reset();

      // directed cycle table
      for (int i = 0; i < 26; i++) begin
         @(posedge clk); #1;
         bus.i_read = vt[i].ir; bus.d_read = vt[i].dr; bus.d_write = vt[i].dw;
         bus.i_address = vt[i].ia; bus.d_address = vt[i].da; bus.d_writedata = vt[i].dwd;
         bus.i_byteenable = 4'hF; bus.d_byteenable = 4'h3;
         bus.m_waitrequest = vt[i].mw; bus.m_readdatavalid = vt[i].mrdv;
         bus.m_readdata = vt[i].mrd;
         @(negedge clk);
         chk($sformatf("vec%0d.m_read", i), bus.m_read, vt[i].e_mr);
         chk($sformatf("vec%0d.m_write", i), bus.m_write, vt[i].e_mw);
         if (vt[i].chk_bus) begin
            chk($sformatf("vec%0d.m_address", i), bus.m_address, vt[i].e_ma);
            chk($sformatf("vec%0d.m_writedata", i), bus.m_writedata, vt[i].e_mwd);
         end
         chk($sformatf("vec%0d.i_wait", i), bus.i_waitrequest, vt[i].e_iw);
         chk($sformatf("vec%0d.d_wait", i), bus.d_waitrequest, vt[i].e_dw);
         chk($sformatf("vec%0d.i_rdv", i), bus.i_readdatavalid, vt[i].e_irdv);
         chk($sformatf("vec%0d.d_rdv", i), bus.d_readdatavalid, vt[i].e_drdv);
         chk($sformatf("vec%0d.i_rdata", i), bus.i_readdata, vt[i].mrd);
         chk($sformatf("vec%0d.d_rdata", i), bus.d_readdata, vt[i].mrd);
      end

      // reset while in WAIT_D, then a stray readdatavalid
      @(posedge clk); #1 clr_in(); bus.d_read = 1; bus.d_address = 'h80;
      @(negedge clk); chk_idle("rstw.idle");
      @(posedge clk); #1;
      @(negedge clk); chk("rstw.grant_rd", bus.m_read, 1);
      @(posedge clk); #1 bus.d_read = 0;
      @(negedge clk); chk("rstw.wait_dw", bus.d_waitrequest, 1);
      #1 rst = 0; bus.m_readdatavalid = 1; bus.m_readdata = 'hF00D;
      #1 chk("rstw.in_rst_drdv", bus.d_readdatavalid, 0);
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      chk("rstw.stray_drdv", bus.d_readdatavalid, 0);
      chk("rstw.stray_irdv", bus.i_readdatavalid, 0);
      chk_idle("rstw.after");
      @(posedge clk); #1 bus.m_readdatavalid = 0; bus.i_read = 1; bus.i_address = 'h24;
      @(negedge clk); chk("rstw.new_idle_iw", bus.i_waitrequest, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstw.new_grant_rd", bus.m_read, 1);
      chk("rstw.new_grant_addr", bus.m_address, 'h24);
      chk("rstw.new_grant_iw", bus.i_waitrequest, 0);
      @(posedge clk); #1 bus.i_read = 0;
      @(posedge clk); #1 bus.m_readdatavalid = 1;
      @(negedge clk); chk("rstw.new_irdv", bus.i_readdatavalid, 1);
      @(posedge clk); #1 bus.m_readdatavalid = 0;

      // d_read and d_write together is issued as a write
      @(posedge clk); #1 bus.d_read = 1; bus.d_write = 1; bus.d_address = 'h44; bus.d_writedata = 'h77;
      @(negedge clk); chk_idle("rw.idle");
      @(posedge clk); #1;
      @(negedge clk);
      chk("rw.m_write", bus.m_write, 1);
      chk("rw.m_read", bus.m_read, 0);
      chk("rw.m_wd", bus.m_writedata, 'h77);
      chk("rw.d_wait", bus.d_waitrequest, 0);
      @(posedge clk); #1 bus.d_read = 0; bus.d_write = 0;
      @(negedge clk); chk_idle("rw.done");

      // random traffic against a transaction-level model
      do_reset();
      mdl_busy = 0; mdl_wait = 0; mdl_own = 0; mdl_last = 0;
      hi_st = 0; hd_st = 0; hd_wr = 0; rd_cnt = -1;
      ir_n = 0; dr_n = 0; dw_n = 0; mw_n = 0; mrdv_n = 0;
      ia_n = 0; da_n = 0; dwd_n = 0; mrd_n = 0; ibe_n = 0; dbe_n = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        e_mr, e_mw, e_iw, e_dw, e_ir, e_dr, bchk, req;
         logic [31:0] e_ma, e_wd;
         logic [3:0]  e_be;
         @(posedge clk); #1;
         bus.i_read = ir_n; bus.i_address = ia_n; bus.i_byteenable = ibe_n;
         bus.d_read = dr_n; bus.d_write = dw_n; bus.d_address = da_n;
         bus.d_byteenable = dbe_n; bus.d_writedata = dwd_n;
         bus.m_waitrequest = mw_n; bus.m_readdatavalid = mrdv_n; bus.m_readdata = mrd_n;
         @(negedge clk);
         e_mr = 0; e_mw = 0; e_ma = 0; e_be = 0; e_wd = 0;
         e_iw = 1; e_dw = 1; e_ir = 0; e_dr = 0; bchk = 1;
         if (mdl_busy && !mdl_wait) begin
            if (mdl_own == 0) begin
               e_mr = bus.i_read; e_ma = bus.i_address; e_be = bus.i_byteenable;
               e_iw = bus.m_waitrequest;
            end else begin
               e_mw = bus.d_write; e_mr = bus.d_read && !bus.d_write;
               e_ma = bus.d_address; e_be = bus.d_byteenable; e_wd = bus.d_writedata;
               e_dw = bus.m_waitrequest;
            end
         end else if (mdl_busy) begin
            bchk = 0;
            if (mdl_own == 0) e_ir = bus.m_readdatavalid;
            else              e_dr = bus.m_readdatavalid;
         end
         chk("rnd.m_read", bus.m_read, e_mr);
         chk("rnd.m_write", bus.m_write, e_mw);
         if (bchk) begin
            chk("rnd.m_address", bus.m_address, e_ma);
            chk("rnd.m_be", bus.m_byteenable, e_be);
            chk("rnd.m_wd", bus.m_writedata, e_wd);
         end
         chk("rnd.i_wait", bus.i_waitrequest, e_iw);
         chk("rnd.d_wait", bus.d_waitrequest, e_dw);
         chk("rnd.i_rdv", bus.i_readdatavalid, e_ir);
         chk("rnd.d_rdv", bus.d_readdatavalid, e_dr);
         chk("rnd.rdata", {bus.i_readdata, bus.d_readdata}, {bus.m_readdata, bus.m_readdata});

         // model advance
         if (!mdl_busy) begin
            if (bus.i_read || bus.d_read || bus.d_write) begin
               if (bus.i_read && (bus.d_read || bus.d_write)) mdl_own = (mdl_last == 0) ? 1 : 0;
               else                                           mdl_own = bus.i_read ? 0 : 1;
               mdl_busy = 1; mdl_wait = 0; mdl_last = mdl_own;
            end
         end else if (!mdl_wait) begin
            req = (mdl_own == 0) ? bus.i_read : (bus.d_read || bus.d_write);
            if (!req) mdl_busy = 0;
            else if (!bus.m_waitrequest) begin
               if (mdl_own == 1 && bus.d_write) mdl_busy = 0;
               else mdl_wait = 1;
            end
         end else if (bus.m_readdatavalid) begin
            mdl_busy = 0;
         end

         // hosts react to what they saw this cycle
         if (hi_st == 1 && !bus.i_waitrequest) hi_st = 2;
         else if (hi_st == 2 && bus.i_readdatavalid) hi_st = 0;
         if (hi_st == 0 && $urandom_range(0, 3) == 0) begin
            hi_st = 1; ia_n = $urandom; ibe_n = 4'($urandom);
         end
         ir_n = (hi_st == 1);
         if (hd_st == 1 && !bus.d_waitrequest) hd_st = hd_wr ? 0 : 2;
         else if (hd_st == 2 && bus.d_readdatavalid) hd_st = 0;
         if (hd_st == 0 && $urandom_range(0, 2) == 0) begin
            hd_st = 1; hd_wr = 1'($urandom); da_n = $urandom; dbe_n = 4'($urandom);
            dwd_n = $urandom;
         end
         dr_n = (hd_st == 1) && !hd_wr;
         dw_n = (hd_st == 1) && hd_wr;

         // agent: random stalls, 1..3 cycle read latency, rare stray valids
         mrdv_n = 0;
         if (rd_cnt == 0) begin mrdv_n = 1; rd_cnt = -1; end
         else if (rd_cnt > 0) rd_cnt--;
         if (bus.m_read && !bus.m_waitrequest) begin
            lat = $urandom_range(0, 2);
            if (lat == 0) mrdv_n = 1;
            else rd_cnt = lat - 1;
         end else if (rd_cnt < 0 && !mrdv_n && $urandom_range(0, 19) == 0) begin
            mrdv_n = 1;
         end
         mw_n  = ($urandom_range(0, 2) == 0);
         mrd_n = $urandom;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
